// File: rtl/crc_32_check_rx_pkg.sv
// Shared definitions for the receive-side CRC-32 checker: lane width,
// polynomial, default seed/xorout, FSM state type and the 48-bit step function.
package crc_32_check_rx_pkg;

  localparam int unsigned LANE_W             = 48;
  localparam logic [31:0] CRC_POLY           = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT_DEFAULT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // One 48-bit lane through the MSB-first CRC-32 LFSR (bit 47 enters first).
  function automatic logic [31:0] crc32_step48(input logic [31:0]       crc,
                                               input logic [LANE_W-1:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < LANE_W; i++) begin
      fb = c[31] ^ data[LANE_W-1-i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_32_check_rx_lane_chain.sv
// Combinational chain of PARALLEL_DEPTH CRC-32 lane steps in ascending lane
// order; a lane whose keep bit is clear passes the CRC through unchanged.
module crc_32_lane_chain
  import crc_32_check_rx_pkg::*;
#(
  parameter int unsigned PARALLEL_DEPTH = 4
) (
  input  logic [31:0]                      crc_in,
  input  logic [PARALLEL_DEPTH-1:0]        keep,
  input  logic [PARALLEL_DEPTH*LANE_W-1:0] data,
  output logic [31:0]                      crc_out
);

  // Fold each kept lane into the running CRC, lane 0 first.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < PARALLEL_DEPTH; i++) begin
      if (keep[i]) begin
        c = crc32_step48(c, data[i*LANE_W +: LANE_W]);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_32_check_rx.sv
// Receive-side CRC-32 checker for the 48-bit-lane datapath. Accumulates CRC
// over framed beats, compares against the received FCS on EOF and holds a
// one-deep registered result. Optional statistics counters are built when
// CRC_32_CHECK_STATS_EN is defined; otherwise ERR_CNT/ABORT_CNT read zero.
module crc_32_check_rx
  import crc_32_check_rx_pkg::*;
#(
  parameter int unsigned PARALLEL_DEPTH = 4,
  parameter logic [31:0] CRC_INIT       = CRC_INIT_DEFAULT,
  parameter logic [31:0] CRC_XOROUT     = CRC_XOROUT_DEFAULT
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  input  logic                             IN_SOF,
  input  logic                             IN_EOF,
  input  logic [PARALLEL_DEPTH-1:0]        IN_KEEP,
  input  logic [PARALLEL_DEPTH*LANE_W-1:0] IN_DATA,
  input  logic [31:0]                      IN_FCS,
  output logic                             RES_VALID,
  input  logic                             RES_READY,
  output logic                             RES_OK,
  output logic [31:0]                      RES_CRC,
  output logic [15:0]                      ERR_CNT,
  output logic [15:0]                      ABORT_CNT
);

  state_t      state;
  state_t      state_next;
  logic [31:0] acc;
  logic [31:0] seed;
  logic [31:0] chain_out;
  logic [31:0] final_crc;
  logic        final_ok;
  logic        accept;
  logic        take_beat;
  logic        finish;

  assign IN_READY = !RES_VALID || RES_READY;
  assign accept   = IN_VALID && IN_READY;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: SOF always (re)opens a frame; EOF closes whatever was taken.
  always_comb begin
    state_next = state;
    if (accept && (IN_SOF || state == FRAME)) begin
      state_next = IN_EOF ? IDLE : FRAME;
    end
  end

  // Beat qualification, chain seed and final comparison.
  always_comb begin
    take_beat = accept && (IN_SOF || state == FRAME);
    finish    = take_beat && IN_EOF;
    seed      = IN_SOF ? CRC_INIT : acc;
    final_crc = chain_out ^ CRC_XOROUT;
    final_ok  = (final_crc == IN_FCS);
  end

  crc_32_lane_chain #(
    .PARALLEL_DEPTH (PARALLEL_DEPTH)
  ) u_chain (
    .crc_in  (seed),
    .keep    (IN_KEEP),
    .data    (IN_DATA),
    .crc_out (chain_out)
  );

  // Running accumulator; re-armed to CRC_INIT once a frame completes.
  always_ff @(posedge CLK) begin
    if (RST)            acc <= CRC_INIT;
    else if (take_beat) acc <= IN_EOF ? CRC_INIT : chain_out;
  end

  // One-deep result register; a consume and a new load may share a cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES_OK    <= 1'b0;
      RES_CRC   <= '0;
    end else begin
      if (RES_VALID && RES_READY) RES_VALID <= 1'b0;
      if (finish) begin
        RES_VALID <= 1'b1;
        RES_OK    <= final_ok;
        RES_CRC   <= final_crc;
      end
    end
  end

`ifdef CRC_32_CHECK_STATS_EN
  logic abort_evt;
  assign abort_evt = accept && ((IN_SOF && state == FRAME) ||
                                (!IN_SOF && state == IDLE && IN_EOF));

  // Saturating failed-frame and aborted/orphan-frame counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_CNT   <= '0;
      ABORT_CNT <= '0;
    end else begin
      if (finish && !final_ok && ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
      if (abort_evt && ABORT_CNT != 16'hFFFF)         ABORT_CNT <= ABORT_CNT + 16'd1;
    end
  end
`else
  assign ERR_CNT   = '0;
  assign ABORT_CNT = '0;
`endif

endmodule

// File: tb/tb_crc_32_check_rx.sv
// Scoreboard bench for crc_32_check_rx: stimulus pushes expected results,
// a negedge monitor compares them when the DUT presents RES_VALID.
module tb_crc_32_check_rx;

`ifdef CRC_32_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic         IN_SOF = 1'b0;
  logic         IN_EOF = 1'b0;
  logic [3:0]   IN_KEEP = '0;
  logic [191:0] IN_DATA = '0;
  logic [31:0]  IN_FCS = '0;
  logic         RES_VALID;
  logic         RES_READY = 1'b1;
  logic         RES_OK;
  logic [31:0]  RES_CRC;
  logic [15:0]  ERR_CNT;
  logic [15:0]  ABORT_CNT;

  crc_32_check_rx #(
    .PARALLEL_DEPTH (4),
    .CRC_INIT       (32'hFFFF_FFFF),
    .CRC_XOROUT     (32'hFFFF_FFFF)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_SOF    (IN_SOF),
    .IN_EOF    (IN_EOF),
    .IN_KEEP   (IN_KEEP),
    .IN_DATA   (IN_DATA),
    .IN_FCS    (IN_FCS),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_OK    (RES_OK),
    .RES_CRC   (RES_CRC),
    .ERR_CNT   (ERR_CNT),
    .ABORT_CNT (ABORT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] crc;
    logic        ok;
  } exp_t;

  exp_t       sbq[$];
  bit [7:0]   fb[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         exp_err = 0;
  int         exp_abort = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference over a byte stream (MSB of each byte first).
  function automatic logic [31:0] golden(input bit [7:0] q[$]);
    logic [31:0] c;
    logic        f;
    c = 32'hFFFF_FFFF;
    foreach (q[k]) begin
      for (int j = 7; j >= 0; j--) begin
        f = c[31] ^ q[k][j];
        c = {c[30:0], 1'b0};
        if (f) c = c ^ 32'h04C1_1DB7;
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  // Append kept lanes of a beat to the frame byte stream, lane 0 first.
  task automatic add_lanes(input logic [3:0] keep, input logic [191:0] data);
    for (int i = 0; i < 4; i++) begin
      if (keep[i]) begin
        for (int b = 5; b >= 0; b--) fb.push_back(data[i*48 + b*8 +: 8]);
      end
    end
  endtask

  // Present one beat, starting #1 after a rising edge; returns #1 after acceptance.
  task automatic beat(input bit sof, input bit eof, input logic [3:0] keep,
                      input logic [191:0] data, input logic [31:0] fcs);
    bit acc;
    acc = 1'b0;
    IN_VALID = 1'b1; IN_SOF = sof; IN_EOF = eof;
    IN_KEEP = keep;  IN_DATA = data; IN_FCS = fcs;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      if (acc) break;
    end
    if (!acc) chk("beat_accept_timeout", {31'b0, acc}, 32'd1);
    IN_VALID = 1'b0; IN_SOF = 1'b0; IN_EOF = 1'b0;
    IN_KEEP = '0;    IN_DATA = '0;  IN_FCS = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sbq.size() == 0 && !RES_VALID) break;
      @(posedge CLK);
      #1;
    end
    chk("drain_queue", sbq.size(), 32'd0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_err_cnt"},   {16'b0, ERR_CNT},   STATS ? exp_err   : 0);
    chk({tag, "_abort_cnt"}, {16'b0, ABORT_CNT}, STATS ? exp_abort : 0);
  endtask

  // Result monitor: compare when a result is presented, pop when consumed.
  always @(negedge CLK) begin
    if (!RST && RES_VALID) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got RES_CRC %h with no result expected", RES_CRC);
      end else begin
        chk("res_crc", RES_CRC, sbq[0].crc);
        chk("res_ok", {31'b0, RES_OK}, {31'b0, sbq[0].ok});
        if (RES_READY) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  localparam logic [191:0] D1 = 192'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978;
  localparam logic [191:0] D2 = 192'hDEADBEEFCAFEF00D_5555AAAA3333CCCC_1122334455667788;
  localparam logic [191:0] D3 = 192'h8000000000000001_7FFFFFFFFFFFFFFE_A5A5A5A5C3C3C3C3;

  initial begin
    logic [31:0] g1, g;
    exp_t        e;

    // Reference anchor: CRC-32/BZIP2 check value of "123456789".
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'h31 + i[7:0]);
    chk("model_anchor", golden(fb), 32'hFC89_1918);

    // Reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("in_ready_in_reset", {31'b0, IN_READY}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_res_valid", {31'b0, RES_VALID}, 32'd0);
    chk("rst_res_ok",    {31'b0, RES_OK},    32'd0);
    chk("rst_res_crc",   RES_CRC,            32'd0);
    chk("rst_in_ready",  {31'b0, IN_READY},  32'd1);
    chk_cnt("rst");

    // Single-beat frame, all lanes kept, correct FCS
    fb.delete(); add_lanes(4'b1111, D1); g1 = golden(fb);
    e.crc = g1; e.ok = 1'b1; sbq.push_back(e);
    beat(1, 1, 4'b1111, D1, g1);
    chk("latency_res_valid", {31'b0, RES_VALID}, 32'd1);
    drain();
    chk_cnt("good_frame");

    // Same frame with FCS bit 0 flipped
    e.crc = g1; e.ok = 1'b0; sbq.push_back(e);
    exp_err++;
    beat(1, 1, 4'b1111, D1, g1 ^ 32'd1);
    drain();
    chk_cnt("bad_fcs");

    // Three-beat frame: KEEP 1111, 0000, 0101
    fb.delete(); add_lanes(4'b1111, D1); add_lanes(4'b0101, D3); g = golden(fb);
    e.crc = g; e.ok = 1'b1; sbq.push_back(e);
    beat(1, 0, 4'b1111, D1, 32'h0);
    beat(0, 0, 4'b0000, D2, 32'h0);
    beat(0, 1, 4'b0101, D3, g);
    drain();

    // Single-beat frame with no kept lanes: INIT ^ XOROUT = 0
    e.crc = 32'h0; e.ok = 1'b1; sbq.push_back(e);
    beat(1, 1, 4'b0000, D2, 32'h0);
    drain();

    // SOF, data, second SOF before EOF: first frame aborted
    fb.delete(); add_lanes(4'b0011, D1); add_lanes(4'b1000, D3); g = golden(fb);
    e.crc = g; e.ok = 1'b1; sbq.push_back(e);
    exp_abort++;
    beat(1, 0, 4'b1111, D2, 32'h0);
    beat(0, 0, 4'b1111, D3, 32'h0);
    beat(1, 0, 4'b0011, D1, 32'h0);
    beat(0, 1, 4'b1000, D3, g);
    drain();
    chk_cnt("abort");

    // Backpressure: hold result 5 cycles, then consume and replace same cycle
    RES_READY = 1'b0;
    e.crc = g1; e.ok = 1'b1; sbq.push_back(e);
    beat(1, 1, 4'b1111, D1, g1);
    repeat (5) begin
      @(negedge CLK);
      chk("stall_in_ready", {31'b0, IN_READY}, 32'd0);
      @(posedge CLK); #1;
    end
    RES_READY = 1'b1;
    fb.delete(); add_lanes(4'b0110, D2); g = golden(fb);
    e.crc = g; e.ok = 1'b1; sbq.push_back(e);
    beat(1, 1, 4'b0110, D2, g);
    chk("b2b_res_valid", {31'b0, RES_VALID}, 32'd1);
    drain();

    // Reset with a result pending discards it
    RES_READY = 1'b0;
    e.crc = g1; e.ok = 1'b1; sbq.push_back(e);
    beat(1, 1, 4'b1111, D1, g1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sbq.delete();
    exp_err = 0; exp_abort = 0;
    RES_READY = 1'b1;
    chk("pend_rst_res_valid", {31'b0, RES_VALID}, 32'd0);
    chk("pend_rst_res_crc",   RES_CRC,            32'd0);
    chk_cnt("pend_rst");

    // Mid-frame reset, then orphan EOF in IDLE
    beat(1, 0, 4'b1111, D1, 32'h0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("mid_rst_res_valid", {31'b0, RES_VALID}, 32'd0);
    chk("mid_rst_res_ok",    {31'b0, RES_OK},    32'd0);
    chk("mid_rst_res_crc",   RES_CRC,            32'd0);
    chk_cnt("mid_rst");
    exp_abort++;
    beat(0, 1, 4'b1111, D2, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("orphan_res_valid", {31'b0, RES_VALID}, 32'd0);
    chk_cnt("orphan");

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
